// File: rtl/lsu_mem_master_pkg.sv
// Shared definitions for the load/store memory master: width codes, FSM states.
package lsu_mem_master_pkg;

    localparam int LSU_XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_STORE  = 3'd3,
        ST_RESP   = 3'd4
    } lsu_state_e;

endpackage

// File: rtl/lsu_mem_master_lane_align.sv
// Byte-lane handling: extract/extend a load from a word, or merge a sub-word store into a word.
module lsu_lane_align
    import lsu_mem_master_pkg::*;
(
    input  logic [LSU_XLEN-1:0] word_i,
    input  logic [LSU_XLEN-1:0] wdata_i,
    input  logic [1:0]          off_i,
    input  logic [2:0]          funct3_i,
    output logic [LSU_XLEN-1:0] load_o,
    output logic [LSU_XLEN-1:0] merge_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word_i[{off_i, 3'b000} +: 8];
        half_v = off_i[1] ? word_i[31:16] : word_i[15:0];

        load_o = word_i;
        case (funct3_i)
            F3_LB:   load_o = {{24{byte_v[7]}}, byte_v};
            F3_LH:   load_o = {{16{half_v[15]}}, half_v};
            F3_LBU:  load_o = {24'h0, byte_v};
            F3_LHU:  load_o = {16'h0, half_v};
            default: load_o = word_i;
        endcase

        merge_o = word_i;
        case (funct3_i)
            F3_SB: merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
            F3_SH: begin
                if (off_i[1]) merge_o[31:16] = wdata_i[15:0];
                else          merge_o[15:0]  = wdata_i[15:0];
            end
            default: merge_o = word_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-organised data memory; sub-word stores are read-modify-write.
//  state     | meaning
//  IDLE      | ready for a request
//  LOAD      | memory read, lane select and extend
//  RMW_RD    | read old word, merge SB/SH data
//  STORE     | full-word write commits at the exit edge
//  RESP      | response held until resp_ready
module lsu_mem_master #(
    parameter int MEM_WORDS = 64,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_read,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);
    import lsu_mem_master_pkg::*;

    lsu_state_e      state_q, state_d;
    logic            we_q, we_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      off_q, off_d;
    logic [XLEN-1:0] idx_q, idx_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] wbuf_q, wbuf_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [XLEN-1:0] req_idx;
    logic            acc_err;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] merge_data;

    lsu_lane_align u_align (
        .word_i   (mem_rdata),
        .wdata_i  (wdata_q),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .load_o   (load_data),
        .merge_o  (merge_data)
    );

    // Fault decode: illegal width code, misalignment, or word index past the memory.
    always_comb begin
        req_idx = {2'b00, req_addr[XLEN-1:2]};
        acc_err = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7)
               || (req_we && req_funct3[2])
               || (((req_funct3 == F3_LH) || (req_funct3 == F3_LHU)) && req_addr[0])
               || ((req_funct3 == F3_LW) && (req_addr[1:0] != 2'b00))
               || (req_idx >= XLEN'(MEM_WORDS));
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wbuf_d  = wbuf_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    off_d   = req_addr[1:0];
                    idx_d   = req_idx;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = acc_err;
                    if (acc_err)                 state_d = ST_RESP;
                    else if (!req_we)            state_d = ST_LOAD;
                    else if (req_funct3 == F3_SW) begin
                        wbuf_d  = req_wdata;
                        state_d = ST_STORE;
                    end
                    else                         state_d = ST_RMW_RD;
                end
            end
            ST_LOAD: begin
                rdata_d = load_data;
                state_d = ST_RESP;
            end
            ST_RMW_RD: begin
                wbuf_d  = merge_data;
                state_d = ST_STORE;
            end
            ST_STORE: state_d = ST_RESP;
            ST_RESP:  if (resp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            idx_q   <= '0;
            wdata_q <= '0;
            wbuf_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wbuf_q  <= wbuf_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Memory strobes decode from state only, so reset drops them without a clock.
    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        resp_valid = (state_q == ST_RESP);
        mem_read   = (state_q == ST_LOAD) || (state_q == ST_RMW_RD);
        mem_write  = (state_q == ST_STORE);
        mem_addr   = idx_q;
        mem_wdata  = wbuf_q;
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master with a behavioural 64-word memory.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_mem_master #(.MEM_WORDS(64), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Behavioural memory with a preload port and write/read activity counters.
    logic [31:0] mem [64];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_data = 32'h0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [31:0] last_wa = 32'h0;
    logic [31:0] last_wd = 32'h0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (mem_write) begin
            mem[mem_addr[5:0]] <= mem_wdata;
            wr_cnt  <= wr_cnt + 1;
            last_wa <= mem_addr;
            last_wd <= mem_wdata;
        end
        if (mem_read) rd_cnt <= rd_cnt + 1;
    end
    assign mem_rdata = (mem_read && mem_addr < 32'd64) ? mem[mem_addr[5:0]] : 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];
    logic seen = 1'b0;

    // Monitor: every cycle a response is shown it must match the head entry.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
            end else begin
                check({sb[0].name, "_req_ready"}, {31'h0, req_ready}, 32'h0);
                if (!seen) begin
                    seen = 1'b1;
                    // accept edge counts as the first cycle of latency
                    check({sb[0].name, "_latency"}, 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
                end
                check({sb[0].name, "_rdata"}, resp_rdata, sb[0].rdata);
                check({sb[0].name, "_err"}, {31'h0, resp_err}, {31'h0, sb[0].err});
                if (resp_ready) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input int lat, input string name);
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        e.rdata = exp_rd; e.err = exp_err; e.lat = lat; e.acc = cyc; e.name = name;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending responses expected 0", name, sb.size());
            sb.delete();
        end
        check({name, "_idle"}, {31'h0, req_ready}, 32'h1);
    endtask

    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                       input int lat, input string name);
        send(we, f3, addr, wd, exp_rd, exp_err, lat, name);
        wait_idle(name);
    endtask

    // Fault cases must leave the memory untouched.
    task automatic err_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input string name);
        int rd0, wr0;
        rd0 = rd_cnt; wr0 = wr_cnt;
        txn(we, f3, addr, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, name);
        check({name, "_reads"}, 32'(rd_cnt - rd0), 32'h0);
        check({name, "_writes"}, 32'(wr_cnt - wr0), 32'h0);
    endtask

    initial begin
        int wr0, n;

        #12;
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", {31'h0, resp_err}, 32'h0);
        check("rst_mem_rw", {30'h0, mem_read, mem_write}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        preload(6'd5, 32'h8070_F0A1);
        preload(6'd3, 32'h1122_3344);

        txn(1'b0, 3'd0, 32'h15, 32'h0, 32'hFFFF_FFF0, 1'b0, 2, "lb");
        txn(1'b0, 3'd4, 32'h15, 32'h0, 32'h0000_00F0, 1'b0, 2, "lbu");
        txn(1'b0, 3'd1, 32'h16, 32'h0, 32'hFFFF_8070, 1'b0, 2, "lh");
        txn(1'b0, 3'd5, 32'h16, 32'h0, 32'h0000_8070, 1'b0, 2, "lhu");
        txn(1'b0, 3'd0, 32'h14, 32'h0, 32'hFFFF_FFA1, 1'b0, 2, "lb_b0");
        txn(1'b0, 3'd2, 32'h14, 32'h0, 32'h8070_F0A1, 1'b0, 2, "lw5");

        wr0 = wr_cnt;
        txn(1'b1, 3'd2, 32'h40, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, "sw");
        check("sw_pulses", 32'(wr_cnt - wr0), 32'h1);
        check("sw_mem_addr", last_wa, 32'd16);
        check("sw_mem_wdata", last_wd, 32'hDEAD_BEEF);
        txn(1'b0, 3'd2, 32'h40, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, "lw_after_sw");

        wr0 = wr_cnt;
        txn(1'b1, 3'd0, 32'h0E, 32'h1234_56AA, 32'h0, 1'b0, 3, "sb");
        check("sb_pulses", 32'(wr_cnt - wr0), 32'h1);
        check("sb_mem_wdata", last_wd, 32'h11AA_3344);
        txn(1'b1, 3'd1, 32'h0C, 32'hCAFE_BEEF, 32'h0, 1'b0, 3, "sh");
        check("sh_mem_wdata", last_wd, 32'h11AA_BEEF);
        check("sh_mem_word3", mem[3], 32'h11AA_BEEF);

        err_txn(1'b0, 3'd1, 32'h03, "err_lh_misalign");
        err_txn(1'b1, 3'd2, 32'h42, "err_sw_misalign");
        err_txn(1'b0, 3'd2, 32'h100, "err_lw_range");
        err_txn(1'b0, 3'd3, 32'h10, "err_funct3_3");
        err_txn(1'b1, 3'd4, 32'h10, "err_store_f3_4");

        // Back-pressure: response must hold for five cycles, then one handshake.
        resp_ready = 1'b0;
        send(1'b0, 3'd2, 32'h40, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, "lw_bp");
        n = 0;
        while (!resp_valid && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        repeat (5) @(posedge clk);
        #1 resp_ready = 1'b1;
        wait_idle("lw_bp");
        @(posedge clk);
        #1 check("lw_bp_no_second_resp", {31'h0, resp_valid}, 32'h0);

        // Reset while an SB is in STORE: no write, no response.
        wr0 = wr_cnt;
        send(1'b1, 3'd0, 32'h0D, 32'h0000_0055, 32'h0, 1'b0, 3, "sb_rst");
        n = 0;
        while (!mem_write && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("sb_rst_in_store", {31'h0, mem_write}, 32'h1);
        rst = 1'b1;
        sb.delete();
        seen = 1'b0;
        #1;
        check("sb_rst_write_drop", {31'h0, mem_write}, 32'h0);
        check("sb_rst_req_ready", {31'h0, req_ready}, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        check("sb_rst_word3", mem[3], 32'h11AA_BEEF);
        check("sb_rst_writes", 32'(wr_cnt - wr0), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 check("post_rst_idle", {30'h0, resp_valid, req_ready}, 32'h1);
        end
        txn(1'b0, 3'd2, 32'h0C, 32'h0, 32'h11AA_BEEF, 1'b0, 2, "lw_post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that drives the word-organised data memory's MemRead/MemWrite/address/write_data/read_data interface on behalf of the core's MEM stage.
- Accepts RV32I load/store requests over a valid/ready handshake and converts byte addresses to word indices.
- Performs byte-lane extraction and sign/zero extension for LB/LH/LW/LBU/LHU.
- Implements SB/SH as read-modify-write, because the memory has only full-word writes.
- Flags misaligned, out-of-range and illegal-funct3 accesses without touching memory.

Parameters:
- MEM_WORDS, 64, number of 32-bit words in the attached memory; valid word index range 0..MEM_WORDS-1.
- XLEN, 32, data and address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data (rs2), low byte/half used for SB/SH.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  access faulted (misaligned / out of range / illegal funct3).
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable, sampled by memory on rising edge.
- mem_addr  out  32  word index = req_addr >> 2.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  combinational memory read data, valid while mem_read = 1.

Behaviour:
- States: IDLE, LOAD, RMW_RD, STORE, RESP. State register is async-reset to IDLE.
- mem_read is 1 in LOAD and RMW_RD only. mem_write is 1 in STORE only. Both decode directly from state and are never glitched by request inputs.
- Reset values: req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_read = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0.
- IDLE, on req_valid & req_ready:
  - Register we, funct3, addr[1:0], word index, wdata.
  - Error checks:
    - funct3 in {3, 6, 7}, or store with funct3 in {4, 5}: error.
    - Half access (funct3 1 or 5) with addr[0] = 1: error.
    - Word access with addr[1:0] != 0: error.
    - Word index >= MEM_WORDS: error.
  - On error: go to RESP with resp_err = 1.
  - Else load goes to LOAD; SW goes to STORE with wbuf = wdata; SB/SH go to RMW_RD.
- LOAD (1 cycle):
  - Sample mem_rdata and select the lane, little-endian: byte k = bits [8k+7:8k]; half at addr[1] = 1 is bits [31:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Next state RESP.
- RMW_RD (1 cycle):
  - wbuf = mem_rdata with the addressed byte or half replaced by req_wdata[7:0] or [15:0]. Other lanes are unchanged.
  - Next state STORE.
- STORE (1 cycle): mem_wdata = wbuf; the write commits at the edge leaving STORE. Next state RESP.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err stay stable until resp_valid & resp_ready, then return to IDLE.
  - Outputs must hold under back-pressure for any number of cycles.
- Latency, from the accept edge to resp_valid: load 2 cycles; SW 2; SB/SH 3; error 1.
- No new request is accepted until the response handshake completes, so req_ready = 0 outside IDLE.
- Reset mid-operation: return to IDLE immediately, mem_write drops asynchronously, and no partial write commits. A request in flight is discarded with no response.
- mem_addr holds the latched word index in all states; 0 after reset.

Decomposition:
- Shared package: funct3 width codes (LB/LH/LW/LBU/LHU/SB/SH/SW), state encoding, XLEN.
- One natural sub-module, lsu_lane_align (combinational), handles both directions:
  - load direction: extract and extend from (word, addr[1:0], funct3);
  - store direction: merge (old word, new data, addr[1:0], funct3).

Test Plan:
- Memory word 5 = 0x8070_F0A1; LB at byte address 0x15 -> resp_rdata 0xFFFF_FFF0 after 2 cycles; LBU at 0x15 -> 0x0000_00F0; LH at 0x16 -> 0xFFFF_8070; LHU at 0x16 -> 0x0000_8070.
- SW 0xDEAD_BEEF at address 0x40 -> one mem_write pulse with mem_addr 16, mem_wdata 0xDEAD_BEEF; a following LW at 0x40 returns 0xDEAD_BEEF.
- Word 3 = 0x1122_3344; SB 0xAA at 0x0E -> RMW_RD, STORE, RESP; mem_wdata 0x11AA_3344; SH 0xBEEF at 0x0C -> 0x11AA_BEEF.
- LH at address 0x03, SW at 0x42, LW at 0x100 (word index 64), funct3 = 3 -> each gives resp_err = 1 one cycle after accept, mem_read = mem_write = 0 throughout, resp_rdata = 0.
- Hold resp_ready = 0 for 5 cycles after an LW -> resp_valid and resp_rdata stable, req_ready = 0, then exactly one handshake and a return to IDLE.
- Assert rst during STORE of an SB -> mem_write falls without a clock edge, target word unchanged, and after release req_ready = 1 with no response issued.
